mux2_1b_gl: RTL and testbench

MUX2_1B_GL -- requirements
Module: mux2_1b_gl

---
 rtl/mux2_1b_gl_pkg.sv | 14 +
 rtl/sat_counter.sv | 21 ++
 rtl/mux2_1b_gl.sv | 46 ++++
 tb/tb_mux2_1b_gl.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/mux2_1b_gl_pkg.sv
// Shared sizing for mux2_1b_gl: default counter width and its saturation limit.
// No logic; constants and a helper only.
package mux2_1b_gl_pkg;

  localparam int COUNT_W_DEF = 8;

  // All-ones value of a w-bit counter; valid for 1 <= w <= 32.
  function automatic logic [31:0] sat_limit(input int w);
    return (32'd1 << w) - 32'd1;
  endfunction

  localparam logic [31:0] SAT_LIMIT = sat_limit(COUNT_W_DEF);

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous active-low clear; sticks at LIMIT.
// Latency: count updates 1 cycle after inc is sampled; backpressure: none.
module sat_counter #(
  parameter int             W     = 8,
  parameter logic [W-1:0]   LIMIT = '1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      count <= '0;
    end else if (inc && (count != LIMIT)) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/mux2_1b_gl.sv
// Gate-level 2:1 mux with a registered copy of its result and a count of sel=1 edges.
// Latency: out is combinational, out_q and sel_count follow 1 cycle later; backpressure: none.
module mux2_1b_gl
  import mux2_1b_gl_pkg::*;
#(
  parameter int COUNT_W = COUNT_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               in0,
  input  logic               in1,
  input  logic               sel,
  output logic               out,
  output logic               out_q,
  output logic [COUNT_W-1:0] sel_count
);

  wire sel_n;
  wire and0;
  wire and1;

  // Mux path is pure gates so it is independent of clk and reset, and lets X through.
  not g_not  (sel_n, sel);
  and g_and0 (and0, in0, sel_n);
  and g_and1 (and1, in1, sel);
  or  g_or   (out, and0, and1);

  always_ff @(posedge clk) begin
    if (!reset) begin
      out_q <= 1'b0;
    end else begin
      out_q <= out;
    end
  end

  sat_counter #(
    .W     (COUNT_W),
    .LIMIT (COUNT_W'(sat_limit(COUNT_W)))
  ) u_sel_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (sel),
    .count (sel_count)
  );

endmodule

// File: tb/tb_mux2_1b_gl.sv
// Self-checking bench for mux2_1b_gl: truth table, reset corners and randomized traffic
// compared against a behavioural model of the mux, the delayed copy and the saturating count.
module tb_mux2_1b_gl;

  logic       clk;
  logic       reset;
  logic       in0;
  logic       in1;
  logic       sel;
  logic       out;
  logic       out_q;
  logic [7:0] sel_count;

  int checks   = 0;
  int failures = 0;

  // Reference model state.
  logic cur_r, cur_a, cur_b, cur_s;
  logic m_q;
  int   m_cnt;

  typedef struct {
    logic a;
    logic b;
    logic s;
    logic exp_out;
  } tt_vec_t;

  tt_vec_t tt[8];

  mux2_1b_gl dut (
    .clk       (clk),
    .reset     (reset),
    .in0       (in0),
    .in1       (in1),
    .sel       (sel),
    .out       (out),
    .out_q     (out_q),
    .sel_count (sel_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic mux_ref(input logic a, input logic b, input logic s);
    return s ? b : a;
  endfunction

  // One clock: advance the model over the edge using the inputs held across it,
  // apply new inputs 1 unit after the edge, then compare 8 units later.
  task automatic cycle(input logic r, input logic a, input logic b, input logic s);
    @(posedge clk);
    if (!cur_r) begin
      m_q   = 1'b0;
      m_cnt = 0;
    end else begin
      m_q = mux_ref(cur_a, cur_b, cur_s);
      if (cur_s) m_cnt = (m_cnt + 1 > 255) ? 255 : m_cnt + 1;
    end
    #1;
    reset = r; in0 = a; in1 = b; sel = s;
    cur_r = r; cur_a = a; cur_b = b; cur_s = s;
    #8;
    chk("out", {31'd0, out}, {31'd0, mux_ref(a, b, s)});
    chk("out_q", {31'd0, out_q}, {31'd0, m_q});
    chk("sel_count", {24'd0, sel_count}, m_cnt);
  endtask

  initial begin
    tt[0] = '{1'b0, 1'b0, 1'b0, 1'b0};
    tt[1] = '{1'b0, 1'b0, 1'b1, 1'b0};
    tt[2] = '{1'b0, 1'b1, 1'b0, 1'b0};
    tt[3] = '{1'b0, 1'b1, 1'b1, 1'b1};
    tt[4] = '{1'b1, 1'b0, 1'b0, 1'b1};
    tt[5] = '{1'b1, 1'b0, 1'b1, 1'b0};
    tt[6] = '{1'b1, 1'b1, 1'b0, 1'b1};
    tt[7] = '{1'b1, 1'b1, 1'b1, 1'b1};

    reset = 1'b0; in0 = 1'b0; in1 = 1'b0; sel = 1'b0;
    cur_r = 1'b0; cur_a = 1'b0; cur_b = 1'b0; cur_s = 1'b0;
    m_q = 1'b0; m_cnt = 0;

    // Reset state.
    cycle(0, 0, 0, 0);
    cycle(0, 0, 0, 0);
    chk("rst_out_q", {31'd0, out_q}, 32'd0);
    chk("rst_sel_count", {24'd0, sel_count}, 32'd0);

    // out follows inputs while reset is held.
    cycle(0, 1, 0, 0);
    cycle(0, 1, 0, 0);
    chk("rst_out_follows", {31'd0, out}, 32'd1);
    chk("rst_hold_out_q", {31'd0, out_q}, 32'd0);
    chk("rst_hold_cnt", {24'd0, sel_count}, 32'd0);
    cycle(0, 0, 1, 1);
    chk("rst_out_sel1", {31'd0, out}, 32'd1);
    chk("rst_cnt_sel1", {24'd0, sel_count}, 32'd0);

    // Exhaustive truth table, in0/in1/sel = 000..111.
    for (int i = 0; i < 8; i++) begin
      cycle(1, tt[i].a, tt[i].b, tt[i].s);
      chk($sformatf("tt_%0d", i), {31'd0, out}, {31'd0, tt[i].exp_out});
    end

    // out_q latency right after reset release.
    cycle(0, 0, 0, 0);
    cycle(1, 0, 1, 1);
    chk("lat_out_n", {31'd0, out}, 32'd1);
    chk("lat_out_q_n", {31'd0, out_q}, 32'd0);
    cycle(1, 0, 1, 1);
    chk("lat_out_q_n1", {31'd0, out_q}, 32'd1);
    chk("lat_cnt_first", {24'd0, sel_count}, 32'd1);

    // Reset asserted with sel=1 while the count reads 10.
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 50 && m_cnt != 9; i++) cycle(1, 0, 0, 1);
    cycle(0, 0, 0, 1);
    chk("mid_cnt_10", {24'd0, sel_count}, 32'd10);
    cycle(1, 0, 0, 1);
    chk("mid_cnt_clr", {24'd0, sel_count}, 32'd0);
    cycle(1, 0, 0, 1);
    chk("mid_cnt_resume", {24'd0, sel_count}, 32'd1);

    // Saturation: 300 cycles of sel=1 with random data.
    cycle(0, 0, 0, 0);
    for (int i = 0; i < 300; i++) cycle(1, 1'($urandom), 1'($urandom), 1);
    chk("sat_255", {24'd0, sel_count}, 32'd255);
    for (int i = 0; i < 5; i++) cycle(1, 1'($urandom), 1'($urandom), 1);
    chk("sat_hold", {24'd0, sel_count}, 32'd255);
    cycle(1, 1, 0, 0);
    chk("sat_sel0_hold", {24'd0, sel_count}, 32'd255);

    // Randomized traffic with occasional resets.
    for (int i = 0; i < 400; i++) begin
      cycle(($urandom_range(0, 15) != 0), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
